// File: rtl/tanh_lut_fetch_sequencer.sv
// tanh_lut_fetch_sequencer
// Front end of the piecewise-linear tanh unit: splits a signed fixed-point x into
// a table index and a fraction, fetches the two bracketing table entries from a
// single-port 1-cycle-latency ROM, and presents them to the interpolator.
// Timing: the accept cycle starts at edge T; the sampling edge is T+1; the result
// is visible from edge T+4. One result is produced every 4 cycles.
module tanh_lut_fetch_sequencer #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int IDX_W  = DATA_W - FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    output logic              rom_rd,
    output logic [IDX_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] base,
    output logic [DATA_W-1:0] next_data,
    output logic [DATA_W-1:0] remaining
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_BASE = 3'd1,
        ST_RD_NEXT = 3'd2,
        ST_WAIT    = 3'd3,
        ST_VALID   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    a0_q, a0_d;
    logic [IDX_W-1:0]    a1_q, a1_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic                rom_rd_q, rom_rd_d;
    logic [IDX_W-1:0]    rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   next_data_q, next_data_d;
    logic [DATA_W-1:0]   remaining_q, remaining_d;
    logic                out_valid_q, out_valid_d;
    logic [IDX_W-1:0]    split_a0_s;
    logic                accept_s;

    // Offset-binary index: flipping the sign bit maps -8..7 onto 0..15.
    assign split_a0_s = {~x[DATA_W-1], x[DATA_W-2:FRAC_W]};
    assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_VALID) & out_ready);
    assign accept_s   = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle fetch, VALID holds until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RD_BASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_BASE: state_d = ST_RD_NEXT;
            ST_RD_NEXT: state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_VALID;
            ST_VALID: begin
                if (out_ready & in_valid) begin
                    state_d = ST_RD_BASE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_VALID;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: capture x on accept, drive ROM, latch returning words.
    always_comb begin
        a0_d        = a0_q;
        a1_d        = a1_q;
        frac_d      = frac_q;
        rom_addr_d  = rom_addr_q;
        base_d      = base_q;
        next_data_d = next_data_q;
        remaining_d = remaining_q;
        if (accept_s) begin
            a0_d   = split_a0_s;
            frac_d = x[FRAC_W-1:0];
            if (split_a0_s == {IDX_W{1'b1}}) begin
                a1_d = split_a0_s;
            end else begin
                a1_d = split_a0_s + IDX_W'(1);
            end
        end else begin
            a0_d = a0_q;
        end
        rom_rd_d    = (state_d == ST_RD_BASE) | (state_d == ST_RD_NEXT);
        out_valid_d = (state_d == ST_VALID);
        if (state_d == ST_RD_BASE) begin
            rom_addr_d = a0_d;
        end else if (state_d == ST_RD_NEXT) begin
            rom_addr_d = a1_q;
        end else begin
            rom_addr_d = rom_addr_q;
        end
        // Result registers only move while the fetch is in flight, so a
        // stalled VALID result stays put.
        if (state_q == ST_RD_NEXT) begin
            base_d      = rom_data;
            remaining_d = {{(DATA_W-FRAC_W){1'b0}}, frac_q};
        end else if (state_q == ST_WAIT) begin
            next_data_d = rom_data;
        end else begin
            base_d = base_q;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0_q        <= {IDX_W{1'b0}};
            a1_q        <= {IDX_W{1'b0}};
            frac_q      <= {FRAC_W{1'b0}};
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= {IDX_W{1'b0}};
            base_q      <= {DATA_W{1'b0}};
            next_data_q <= {DATA_W{1'b0}};
            remaining_q <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            frac_q      <= frac_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            base_q      <= base_d;
            next_data_q <= next_data_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign base      = base_q;
    assign next_data = next_data_q;
    assign remaining = remaining_q;
    assign out_valid = out_valid_q;

endmodule
